bus_rr_arbiter: RTL and testbench

Round-robin arbiter for the shared or1420 system bus: it decides which bus master (CPU instruction/data paths, DMA engines, camera interface) may drive `beginTransaction`/`addressData`, and holds that grant until the transaction completes. It sits in the SoC top level, between the per-master request lines and the shared bus wires that connect to the memory and print slaves. It also runs a bus watchdog: if a transaction stalls, the arbiter terminates it with a bus error.

---
 rtl/bus_arb_pkg.sv | 24 ++
 rtl/bus_rr_picker.sv | 37 +++
 rtl/bus_rr_arbiter.sv | 118 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the or1420 system-bus round-robin arbiter:
// FSM encoding, default watchdog length and a constant clog2 helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StActive = 2'd2,
    StAbort  = 2'd3
  } arbState_t;

  localparam int unsigned DefaultTimeoutCycles = 256;

  // Never returns less than 1 so that one-entry vectors still have a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin select: first requester at or after last+1,
// searching upward with wrap-around.
module bus_rr_picker
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          request,
  input  logic [clog2(NUM_REQ)-1:0]   last,
  output logic [NUM_REQ-1:0]          winner,
  output logic [clog2(NUM_REQ)-1:0]   winnerId
);

  localparam int unsigned IdxW = clog2(NUM_REQ);

  logic            found;
  logic [IdxW-1:0] candIdx;
  int              cand;

  always_comb begin
    winner   = '0;
    winnerId = '0;
    found    = 1'b0;
    candIdx  = '0;
    cand     = 0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand    = (int'(last) + i) % int'(NUM_REQ);
      candIdx = IdxW'(cand);
      if (!found && request[candIdx]) begin
        found           = 1'b1;
        winner[candIdx] = 1'b1;
        winnerId        = candIdx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner arbitration for the shared system bus, with a watchdog
// that terminates stalled transactions with a one-cycle bus error.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          request_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [clog2(NUM_REQ)-1:0]   grant_id_o,
  input  logic                        bus_beginTransaction_i,
  input  logic                        bus_endTransaction_i,
  input  logic                        bus_dataValid_i,
  input  logic                        bus_busy_i,
  output logic                        bus_error_o,
  output logic                        bus_endTransaction_o
);

  localparam int unsigned IdxW   = clog2(NUM_REQ);
  localparam int unsigned TimerW = clog2(TIMEOUT_CYCLES);

  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0]   LastInit = IdxW'(NUM_REQ - 1);

  arbState_t          stateQ;
  logic [TimerW-1:0]  timerQ;
  logic [TimerW-1:0]  timerInc;
  logic               timerDone;
  logic [IdxW-1:0]    lastQ;
  logic [NUM_REQ-1:0] ownerQ;
  logic [NUM_REQ-1:0] pickOh;
  logic [IdxW-1:0]    pickId;
  logic               busActivity;

  bus_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) uPicker (
    .request  (request_i),
    .last     (lastQ),
    .winner   (pickOh),
    .winnerId (pickId)
  );

  assign timerDone   = (timerQ == TimerMax);
  assign timerInc    = timerDone ? timerQ : timerQ + 1'b1;
  assign busActivity = bus_dataValid_i | bus_busy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ               <= StIdle;
      timerQ               <= '0;
      lastQ                <= LastInit;
      ownerQ               <= '0;
      grant_o              <= '0;
      grant_id_o           <= '0;
      bus_error_o          <= 1'b0;
      bus_endTransaction_o <= 1'b0;
    end else begin
      bus_error_o          <= 1'b0;
      bus_endTransaction_o <= 1'b0;

      // The visible grant follows the state register by one edge, which gives
      // the turnaround cycle after release and drops the grant after an abort.
      if (stateQ == StGrant || stateQ == StActive) begin
        grant_o    <= ownerQ;
        grant_id_o <= lastQ;
      end else begin
        grant_o <= '0;
      end

      unique case (stateQ)
        StIdle: begin
          timerQ <= '0;
          if (|request_i) begin
            ownerQ <= pickOh;
            lastQ  <= pickId;
            stateQ <= StGrant;
          end
        end
        StGrant: begin
          if (bus_beginTransaction_i) begin
            timerQ <= '0;
            stateQ <= StActive;
          end else if (!request_i[lastQ]) begin
            stateQ <= StIdle;
          end else if (timerDone) begin
            // A granted master that never begins loses its slot silently.
            stateQ <= StIdle;
          end else begin
            timerQ <= timerInc;
          end
        end
        StActive: begin
          if (bus_endTransaction_i) begin
            stateQ <= StIdle;
          end else if (busActivity) begin
            timerQ <= '0;
          end else if (timerDone) begin
            bus_error_o          <= 1'b1;
            bus_endTransaction_o <= 1'b1;
            stateQ               <= StAbort;
          end else begin
            timerQ <= timerInc;
          end
        end
        StAbort: begin
          timerQ <= '0;
          stateQ <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: a vector table for the basic grant flow
// plus hand-written sequences for rotation, watchdog and reset corner cases.
module tb_bus_rr_arbiter;

  localparam int unsigned NReq    = 4;
  localparam int unsigned Timeout = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NReq-1:0] request;
  logic            beginT;
  logic            endT;
  logic            dataValid;
  logic            busy;
  logic [NReq-1:0] grant;
  logic [1:0]      grantId;
  logic            busError;
  logic            busEnd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(
    .NUM_REQ        (NReq),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .request_i              (request),
    .grant_o                (grant),
    .grant_id_o             (grantId),
    .bus_beginTransaction_i (beginT),
    .bus_endTransaction_i   (endT),
    .bus_dataValid_i        (dataValid),
    .bus_busy_i             (busy),
    .bus_error_o            (busError),
    .bus_endTransaction_o   (busEnd)
  );

  typedef struct {
    logic [3:0] req;
    logic       beg;
    logic       en;
    logic       dv;
    logic       bsy;
    logic [3:0] expGrant;
    logic [1:0] expId;
  } vec_t;

  vec_t vecs[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    request   = '0;
    beginT    = 1'b0;
    endT      = 1'b0;
    dataValid = 1'b0;
    busy      = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int waited;
    int zeros;
    int hi;
    int errSeen;
    int errAt;
    int errCount;
    logic endAtErr;
    logic [3:0] grantAtErr;
    logic [3:0] grantAfterErr;

    //           req      beg   en    dv    bsy   grant    id
    vecs[0]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
    vecs[1]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1};
    vecs[2]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1};
    vecs[3]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1};
    vecs[5]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd1};
    vecs[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1};
    vecs[7]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1};
    vecs[8]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2};
    vecs[9]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 2'd2};
    vecs[10] = '{4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};
    vecs[11] = '{4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3};
    vecs[12] = '{4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3};
    vecs[13] = '{4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3};
    vecs[14] = '{4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0};
    vecs[15] = '{4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0};
    vecs[16] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
    vecs[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
    vecs[18] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
    vecs[19] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2};
    vecs[20] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2};
    vecs[21] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};

    // Reset state
    doReset();
    check("reset_outputs", {24'd0, grant, grantId, busError, busEnd}, 32'd0);

    // Table: priority after reset, release, rotation, withdraw, idle begin
    for (int i = 0; i < 22; i++) begin
      request   = vecs[i].req;
      beginT    = vecs[i].beg;
      endT      = vecs[i].en;
      dataValid = vecs[i].dv;
      busy      = vecs[i].bsy;
      step();
      check($sformatf("vec%0d", i), {24'd0, grant, grantId, busError, busEnd},
            {24'd0, vecs[i].expGrant, vecs[i].expId, 2'b00});
    end
    request = '0; beginT = 1'b0; endT = 1'b0; dataValid = 1'b0; busy = 1'b0;

    // Rotation with all masters requesting: 0,1,2,3,0 with one empty cycle between
    doReset();
    request = 4'b1111;
    waited = 0;
    while (grant == '0 && waited < 10) begin
      step();
      waited++;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_order%0d", k), {28'd0, grant}, 32'd1 << (k % 4));
      beginT = 1'b1;
      step();
      beginT = 1'b0;
      endT   = 1'b1;
      step();
      endT   = 1'b0;
      if (k < 4) begin
        zeros = 0;
        step();
        while (grant == '0 && zeros < 10) begin
          zeros++;
          step();
        end
        check($sformatf("rr_gap%0d", k), zeros, 1);
      end
    end
    request = '0;

    // Normal transaction for master 2: busy stretch then data beats
    doReset();
    request = 4'b0100;
    step();
    step();
    check("norm_grant", {28'd0, grant}, 32'h4);
    beginT = 1'b1;
    step();
    beginT  = 1'b0;
    errSeen = 0;
    busy    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busError || grant != 4'b0100) errSeen++;
    end
    busy      = 1'b0;
    dataValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busError || grant != 4'b0100) errSeen++;
    end
    dataValid = 1'b0;
    endT      = 1'b1;
    request   = 4'b0000;
    step();
    endT = 1'b0;
    check("norm_held", errSeen, 0);
    check("norm_grant_at_end", {28'd0, grant}, 32'h4);
    step();
    check("norm_release", {28'd0, grant, busError, busEnd}, 32'h0);

    // Watchdog: no activity after begin
    doReset();
    request = 4'b0001;
    step();
    step();
    beginT = 1'b1;
    step();
    beginT        = 1'b0;
    errAt         = -1;
    errCount      = 0;
    endAtErr      = 1'b0;
    grantAtErr    = '0;
    grantAfterErr = 4'hf;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (busError) errCount++;
      if (n == errAt + 1) grantAfterErr = grant;
      if (busError && errAt < 0) begin
        errAt      = n;
        endAtErr   = busEnd;
        grantAtErr = grant;
        request    = 4'b0000;
      end
    end
    check("wd_error_cycle", errAt, 16);
    check("wd_end_with_error", {31'd0, endAtErr}, 32'd1);
    check("wd_pulse_count", errCount, 1);
    check("wd_grant_during_pulse", {28'd0, grantAtErr}, 32'h1);
    check("wd_grant_after_pulse", {28'd0, grantAfterErr}, 32'h0);

    // End arrives the same cycle the timer reaches its limit: end wins
    doReset();
    request = 4'b0001;
    step();
    step();
    beginT = 1'b1;
    step();
    beginT  = 1'b0;
    errSeen = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (busError) errSeen++;
    end
    endT = 1'b1;
    request = 4'b0000;
    step();
    endT = 1'b0;
    check("race_no_error", {30'd0, busError, busEnd}, 32'd0);
    check("race_grant_held", {28'd0, grant}, 32'h1);
    step();
    if (busError) errSeen++;
    check("race_release", {28'd0, grant}, 32'h0);
    check("race_no_late_error", errSeen, 0);

    // Granted master never begins: released after the timeout without error
    doReset();
    request = 4'b0001;
    step();
    hi      = 0;
    errSeen = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (busError) errSeen++;
      if (grant != '0) hi++;
      else if (hi > 0) break;
    end
    request = '0;
    check("grant_timeout_len", hi, 16);
    check("grant_timeout_no_err", errSeen, 0);

    // Asynchronous reset in the middle of a transaction
    doReset();
    request = 4'b0100;
    step();
    step();
    beginT = 1'b1;
    step();
    beginT = 1'b0;
    step();
    check("rst_pre_grant", {28'd0, grant}, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {24'd0, grant, grantId, busError, busEnd}, 32'd0);
    step();
    rst     = 1'b0;
    request = 4'b1111;
    step();
    step();
    check("rst_next_owner", {26'd0, grant, grantId}, {26'd0, 4'b0001, 2'd0});
    request = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
